spi_req_arbiter: RTL and testbench

- Shares one spi_master instance between NREQ requesters via round-robin arbitration.
- Sequences each granted multi-word burst:
  - drives spi_en, data_in, data_words and tied_SS;
  - feeds transmit words one at a time from the granted requester;
  - routes each received word back with a one-cycle strobe.
- Sits between client blocks (sensor readers, flash loaders) and the spi_master.

---
 rtl/spi_req_arbiter.sv | 166 ++++++++++++++++
 tb/tb_spi_req_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: round-robin sharing of one spi_master among NREQ burst requesters
module spi_req_arbiter #(
    parameter int DATA_BITS = 8,
    parameter int NREQ = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*6-1:0]         req_len,
    input  logic [NREQ-1:0]           req_tied,
    input  logic [NREQ*DATA_BITS-1:0] req_wdata,
    output logic [NREQ-1:0]           grant,
    output logic [NREQ-1:0]           wr_ack,
    output logic [DATA_BITS-1:0]      rd_data,
    output logic [NREQ-1:0]           rd_valid,
    output logic [NREQ-1:0]           done,
    output logic [NREQ-1:0]           err,
    input  logic                      spi_ready,
    input  logic                      spi_valid,
    input  logic [DATA_BITS-1:0]      spi_rdata,
    output logic                      spi_en,
    output logic [DATA_BITS-1:0]      spi_wdata,
    output logic [5:0]                spi_words,
    output logic                      spi_tied
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic [2:0] {IDLE, LOAD, START, XFER, DONE} state_t;
    state_t state, state_d;
    logic [IW-1:0] ptr, ptr_d, gidx, gidx_d, pick;
    logic found;
    logic [5:0] len, len_d, cnt, cnt_d, pick_len, cnt_inc;
    logic tied, tied_d, spi_en_d, spi_tied_d;
    logic [NREQ-1:0] grant_d, wr_ack_d, rd_valid_d, done_d, err_d, pick_oh;
    logic [DATA_BITS-1:0] rd_data_d, spi_wdata_d, cur_wdata;
    logic [5:0] spi_words_d;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    assign pick_len  = req_len[pick*6 +: 6];
    assign pick_oh   = {{(NREQ-1){1'b0}}, 1'b1} << pick;
    assign cur_wdata = req_wdata[gidx*DATA_BITS +: DATA_BITS];
    assign cnt_inc   = cnt + 6'd1;

    // lowest requester at or after the pointer wins, otherwise lowest below it
    always_comb begin
        found = 1'b0;
        pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && i < int'(ptr)) begin
                found = 1'b1;
                pick = IW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && i >= int'(ptr)) begin
                found = 1'b1;
                pick = IW'(i);
            end
        end
    end

    // burst sequencing: next state and next values of every registered output
    always_comb begin
        state_d = state;
        ptr_d = ptr;
        gidx_d = gidx;
        len_d = len;
        tied_d = tied;
        cnt_d = cnt;
        grant_d = grant;
        wr_ack_d = '0;
        rd_valid_d = '0;
        done_d = '0;
        err_d = '0;
        spi_en_d = 1'b0;
        rd_data_d = rd_data;
        spi_wdata_d = spi_wdata;
        spi_words_d = spi_words;
        spi_tied_d = spi_tied;
        case (state)
            IDLE: if (found) begin
                len_d = pick_len;
                tied_d = req_tied[pick];
                gidx_d = pick;
                if (pick_len == 6'd0 || pick_len > 6'd32) begin
                    err_d = pick_oh;
                    ptr_d = nxt(pick);
                end else begin
                    grant_d = pick_oh;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                spi_wdata_d = cur_wdata;
                spi_words_d = len;
                spi_tied_d = tied;
                wr_ack_d = grant;
                cnt_d = '0;
                state_d = START;
            end
            START: if (spi_ready) begin
                spi_en_d = 1'b1;
                state_d = XFER;
            end
            XFER: if (spi_valid) begin
                rd_data_d = spi_rdata;
                rd_valid_d = grant;
                cnt_d = cnt_inc;
                if (cnt_inc < len) begin
                    spi_wdata_d = cur_wdata;
                    wr_ack_d = grant;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d = grant;
                grant_d = '0;
                ptr_d = nxt(gidx);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers; reset abandons any burst silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr <= '0;
            gidx <= '0;
            len <= '0;
            tied <= 1'b0;
            cnt <= '0;
            grant <= '0;
            wr_ack <= '0;
            rd_valid <= '0;
            done <= '0;
            err <= '0;
            rd_data <= '0;
            spi_en <= 1'b0;
            spi_wdata <= '0;
            spi_words <= '0;
            spi_tied <= 1'b0;
        end else begin
            state <= state_d;
            ptr <= ptr_d;
            gidx <= gidx_d;
            len <= len_d;
            tied <= tied_d;
            cnt <= cnt_d;
            grant <= grant_d;
            wr_ack <= wr_ack_d;
            rd_valid <= rd_valid_d;
            done <= done_d;
            err <= err_d;
            rd_data <= rd_data_d;
            spi_en <= spi_en_d;
            spi_wdata <= spi_wdata_d;
            spi_words <= spi_words_d;
            spi_tied <= spi_tied_d;
        end
    end
endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter: directed bursts checked against a transaction-level model
module tb_spi_req_arbiter;
    localparam int DB = 8;
    localparam int NR = 2;

    logic clk = 1'b0;
    logic rst;
    logic [NR-1:0] req, req_tied;
    logic [NR*6-1:0] req_len;
    logic [NR*DB-1:0] req_wdata;
    logic [NR-1:0] grant, wr_ack, rd_valid, done, err;
    logic [DB-1:0] rd_data, spi_rdata, spi_wdata;
    logic spi_ready, spi_valid, spi_en, spi_tied;
    logic [5:0] spi_words;

    spi_req_arbiter #(.DATA_BITS(DB), .NREQ(NR)) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_tied(req_tied),
        .req_wdata(req_wdata), .grant(grant), .wr_ack(wr_ack), .rd_data(rd_data),
        .rd_valid(rd_valid), .done(done), .err(err), .spi_ready(spi_ready),
        .spi_valid(spi_valid), .spi_rdata(spi_rdata), .spi_en(spi_en),
        .spi_wdata(spi_wdata), .spi_words(spi_words), .spi_tied(spi_tied)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0, cyc = 0;
    logic [DB-1:0] words [NR][64];
    int widx [NR];
    logic [DB-1:0] resp_q[$], tx_q[$], rd_q[$];
    logic [NR-1:0] gnt_log[$];
    logic [NR-1:0] prev_grant = '0;
    bit ms_active;
    int ms_cnt, ms_left;
    int c_en, c_rv, en_cyc, lv_cyc, done_cyc;
    int c_ack [NR], c_done [NR], c_err [NR];
    bit m_busy, m_started;
    logic m_tied;
    int m_owner, m_len, m_cnt, m_t0, m_done_at, m_ptr;
    logic [NR-1:0] e_grant, e_wr_ack, e_rd_valid, e_done, e_err;
    logic e_spi_en, e_spi_tied;
    logic [DB-1:0] e_rd_data, e_spi_wdata;
    logic [5:0] e_spi_words;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    endtask

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] o;
        o = '0;
        o[i] = 1'b1;
        return o;
    endfunction

    task automatic drive_wdata();
        for (int r = 0; r < NR; r++) req_wdata[r*DB +: DB] = words[r][widx[r]];
    endtask

    // what the arbiter must do at this edge, from the inputs it just sampled
    task automatic model_step();
        int p;
        logic [5:0] l;
        e_wr_ack = '0; e_rd_valid = '0; e_done = '0; e_err = '0; e_spi_en = 1'b0;
        if (rst) begin
            m_busy = 0; m_ptr = 0; e_grant = '0; e_rd_data = '0;
            e_spi_wdata = '0; e_spi_words = '0; e_spi_tied = 1'b0;
        end else if (m_busy) begin
            if (cyc == m_t0 + 1) begin
                e_wr_ack = oh(m_owner);
                e_spi_wdata = req_wdata[m_owner*DB +: DB];
                e_spi_words = 6'(m_len);
                e_spi_tied = m_tied;
            end else if (!m_started) begin
                if (spi_ready) begin e_spi_en = 1'b1; m_started = 1; end
            end else if (cyc == m_done_at) begin
                e_done = oh(m_owner); e_grant = '0; m_busy = 0; m_ptr = (m_owner + 1) % NR;
            end else if (spi_valid && m_cnt < m_len) begin
                e_rd_data = spi_rdata;
                e_rd_valid = oh(m_owner);
                m_cnt++;
                if (m_cnt < m_len) begin
                    e_wr_ack = oh(m_owner);
                    e_spi_wdata = req_wdata[m_owner*DB +: DB];
                end else m_done_at = cyc + 1;
            end
        end else if (req != '0) begin
            p = m_ptr;
            while (!req[p]) p = (p + 1) % NR;
            l = req_len[p*6 +: 6];
            if (l == 0 || l > 32) begin
                e_err = oh(p); m_ptr = (p + 1) % NR;
            end else begin
                m_busy = 1; m_owner = p; m_len = int'(l); m_tied = req_tied[p];
                m_t0 = cyc; m_started = 0; m_cnt = 0; m_done_at = -1; e_grant = oh(p);
            end
        end
    endtask

    task automatic ms_reset();
        ms_active = 0; ms_cnt = 0; ms_left = 0; spi_valid = 1'b0; spi_ready = 1'b1;
    endtask

    task automatic clear_stats();
        c_en = 0; c_rv = 0; en_cyc = -1; lv_cyc = -1; done_cyc = -1;
        for (int r = 0; r < NR; r++) begin c_ack[r] = 0; c_done[r] = 0; c_err[r] = 0; end
        tx_q.delete(); rd_q.delete(); gnt_log.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        check("grant", grant, e_grant);
        check("wr_ack", wr_ack, e_wr_ack);
        check("rd_valid", rd_valid, e_rd_valid);
        check("done", done, e_done);
        check("err", err, e_err);
        check("spi_en", spi_en, e_spi_en);
        check("rd_data", rd_data, e_rd_data);
        check("spi_wdata", spi_wdata, e_spi_wdata);
        check("spi_words", spi_words, e_spi_words);
        check("spi_tied", spi_tied, e_spi_tied);
        if (spi_en) begin c_en++; en_cyc = cyc; end
        if (rd_valid != '0) begin c_rv++; rd_q.push_back(rd_data); end
        if (done != '0) done_cyc = cyc;
        if (grant != '0 && prev_grant == '0) gnt_log.push_back(grant);
        prev_grant = grant;
        for (int r = 0; r < NR; r++) begin
            if (wr_ack[r]) begin c_ack[r]++; if (widx[r] < 63) widx[r]++; end
            if (done[r]) c_done[r]++;
            if (err[r]) c_err[r]++;
        end
        drive_wdata();
        spi_valid = 1'b0;
        if (ms_active) begin
            ms_cnt++;
            if (ms_cnt == 4) begin
                spi_valid = 1'b1;
                spi_rdata = (resp_q.size() > 0) ? resp_q[0] : 8'hEE;
                if (resp_q.size() > 0) resp_q.delete(0);
                ms_left--;
                lv_cyc = cyc;
            end
            if (ms_cnt == 6) begin
                if (ms_left == 0) begin ms_active = 0; spi_ready = 1'b1; end
                else begin tx_q.push_back(spi_wdata); ms_cnt = 0; end
            end
        end else if (spi_en) begin
            ms_active = 1; ms_cnt = 0; ms_left = int'(spi_words); spi_ready = 1'b0;
            tx_q.push_back(spi_wdata);
        end
    endtask

    task automatic wait_done(input int r, input int budget);
        int start;
        start = c_done[r];
        for (int i = 0; i < budget && c_done[r] == start; i++) tick();
        check("done_timeout", c_done[r] != start, 1);
    endtask

    task automatic wait_rv(input int n, input int budget);
        for (int i = 0; i < budget && c_rv < n; i++) tick();
        check("rv_timeout", c_rv >= n, 1);
    endtask

    task automatic wait_dones(input int n, input int budget);
        for (int i = 0; i < budget && c_done[0] + c_done[1] < n; i++) tick();
        check("dones_timeout", c_done[0] + c_done[1] >= n, 1);
    endtask

    task automatic reset_words();
        for (int r = 0; r < NR; r++) widx[r] = 0;
        drive_wdata();
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; ms_reset();
        tick(); tick();
        rst = 1'b0; reset_words();
    endtask

    initial begin
        int c0, bad;
        rst = 1'b1; req = '0; req_len = '0; req_tied = '0; spi_rdata = '0;
        ms_reset();
        for (int r = 0; r < NR; r++) for (int i = 0; i < 64; i++) words[r][i] = 8'(r * 64 + i);
        reset_words();
        clear_stats();
        tick(); tick(); tick();
        check("rst_ctl", {grant, wr_ack, rd_valid, done, err, spi_en, spi_tied}, 0);
        check("rst_data", {spi_words, spi_wdata, rd_data}, 0);
        rst = 1'b0;

        // single burst of three words
        words[0][0] = 8'hA5; words[0][1] = 8'h3C; words[0][2] = 8'hF0;
        reset_words();
        resp_q = '{8'h11, 8'h22, 8'h33};
        req_len[5:0] = 6'd3;
        clear_stats();
        req = 2'b01; c0 = cyc;
        wait_done(0, 200);
        req = '0;
        tick(); tick();
        check("t1_en_count", c_en, 1);
        check("t1_en_latency", en_cyc - c0, 3);
        check("t1_done_latency", done_cyc - lv_cyc, 2);
        check("t1_words", spi_words, 3);
        check("t1_acks", c_ack[0], 3);
        check("t1_rd0", rd_q.size() > 0 ? rd_q[0] : 8'hXX, 8'h11);
        check("t1_rd1", rd_q.size() > 1 ? rd_q[1] : 8'hXX, 8'h22);
        check("t1_rd2", rd_q.size() > 2 ? rd_q[2] : 8'hXX, 8'h33);
        check("t1_tx0", tx_q.size() > 0 ? tx_q[0] : 8'hXX, 8'hA5);
        check("t1_tx1", tx_q.size() > 1 ? tx_q[1] : 8'hXX, 8'h3C);
        check("t1_tx2", tx_q.size() > 2 ? tx_q[2] : 8'hXX, 8'hF0);
        check("t1_done_count", c_done[0], 1);
        check("t1_grant_idle", grant, 0);

        // contention from reset, one word each
        do_reset();
        req_len = {6'd1, 6'd1};
        clear_stats();
        req = 2'b11;
        wait_dones(4, 400);
        req = '0;
        tick(); tick();
        check("t2_g0", gnt_log.size() > 0 ? gnt_log[0] : 2'bxx, 2'b01);
        check("t2_g1", gnt_log.size() > 1 ? gnt_log[1] : 2'bxx, 2'b10);
        check("t2_g2", gnt_log.size() > 2 ? gnt_log[2] : 2'bxx, 2'b01);
        check("t2_g3", gnt_log.size() > 3 ? gnt_log[3] : 2'bxx, 2'b10);
        check("t2_en_count", c_en, 4);

        // illegal lengths on requester 1
        reset_words();
        clear_stats();
        req_len = {6'd0, 6'd2};
        req = 2'b10;
        tick();
        check("t3_err_len0", err, 2'b10);
        check("t3_grant_len0", grant, 2'b00);
        req = '0;
        tick();
        req_len[11:6] = 6'd40;
        req = 2'b10;
        tick();
        check("t3_err_len40", err, 2'b10);
        req = '0;
        tick(); tick();
        check("t3_err_count", c_err[1], 2);
        check("t3_no_en", c_en, 0);
        check("t3_grant_idle", grant, 2'b00);
        req = 2'b01;
        wait_done(0, 200);
        req = '0;
        tick();
        check("t3_req0_served", c_done[0], 1);
        check("t3_req0_en", c_en, 1);

        // maximum burst with tied slave select
        for (int i = 0; i < 64; i++) words[0][i] = 8'(i * 7 + 3);
        reset_words();
        resp_q.delete();
        for (int i = 0; i < 32; i++) resp_q.push_back(8'(i) ^ 8'h5A);
        req_len[5:0] = 6'd32; req_tied = 2'b01;
        clear_stats();
        req = 2'b01;
        wait_done(0, 1000);
        req = '0;
        tick();
        check("t4_tied", spi_tied, 1);
        check("t4_words", spi_words, 32);
        check("t4_rv_count", c_rv, 32);
        check("t4_acks", c_ack[0], 32);
        check("t4_done_count", c_done[0], 1);
        check("t4_en_count", c_en, 1);
        check("t4_tx_last", tx_q.size() == 32 ? tx_q[31] : 8'hXX, 8'hDC);
        check("t4_rd_last", rd_q.size() == 32 ? rd_q[31] : 8'hXX, 8'h45);
        bad = 0;
        for (int i = 0; i < 32; i++) if (i >= rd_q.size() || rd_q[i] !== (8'(i) ^ 8'h5A)) bad++;
        check("t4_rd_all", bad, 0);

        // request dropped after the first word
        req_tied = '0; req_len[5:0] = 6'd4;
        reset_words();
        clear_stats();
        req = 2'b01;
        wait_rv(1, 200);
        req = '0;
        wait_done(0, 300);
        tick();
        check("t5_rv_count", c_rv, 4);
        check("t5_done_count", c_done[0], 1);
        check("t5_acks", c_ack[0], 4);
        check("t5_tx_count", tx_q.size(), 4);

        // reset in the middle of a burst, then pointer must be back at 0
        reset_words();
        clear_stats();
        req = 2'b01;
        wait_rv(1, 200);
        rst = 1'b1; ms_reset();
        tick();
        check("t6_rst_ctl", {grant, wr_ack, rd_valid, done, err, spi_en, spi_tied}, 0);
        check("t6_rst_data", {spi_words, spi_wdata, rd_data}, 0);
        check("t6_no_done", c_done[0], 0);
        rst = 1'b0;
        reset_words();
        req_len = {6'd1, 6'd1};
        clear_stats();
        req = 2'b11;
        wait_dones(2, 300);
        req = '0;
        tick(); tick();
        check("t6_first_grant", gnt_log.size() > 0 ? gnt_log[0] : 2'bxx, 2'b01);
        check("t6_second_grant", gnt_log.size() > 1 ? gnt_log[1] : 2'bxx, 2'b10);
        check("t6_done0", c_done[0], 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
